// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctrl_pkg
//  Description : Shared types and constants for the AES round controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;
  localparam int BLK_W  = 128;
  localparam int KIDX_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Round count for the requested key length; AES-256 only when the build allows it
  function automatic logic [KIDX_W-1:0] sel_nr(input logic aes256_en, input logic key_len);
    return (aes256_en && key_len) ? KIDX_W'(NR_256) : KIDX_W'(NR_128);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Sequences one AES block through an external combinational
//                round datapath: initial key add, Nr-1 full rounds and a final
//                round, fetching round keys from an external key store.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter bit AES256_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              ready,
  input  logic              en_de,
  input  logic              key_len,
  input  logic [BLK_W-1:0]  din,
  input  logic              flush,
  output logic [BLK_W-1:0]  dout,
  output logic              done,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [BLK_W-1:0]  key_data,
  output logic              dp_en_de,
  output logic              dp_last,
  output logic [BLK_W-1:0]  dp_block,
  output logic [BLK_W-1:0]  dp_round_key,
  input  logic [BLK_W-1:0]  dp_new_block
);

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    blk_q,   blk_d;
  logic [BLK_W-1:0]    dout_q,  dout_d;
  logic [KIDX_W-1:0]   rnd_q,   rnd_d;
  logic [KIDX_W-1:0]   nr_q,    nr_d;
  logic                en_q,    en_d;
  logic                last_rnd;

  // The last full round is the one numbered Nr-1; the final round follows it
  assign last_rnd = (rnd_q == (nr_q - KIDX_W'(1)));

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = INIT;
        INIT:    state_d = ROUND;
        ROUND:   if (last_rnd) state_d = FINAL;
        FINAL:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: handshake, done pulse and round-key addressing
  always_comb begin
    ready   = 1'b0;
    done    = 1'b0;
    dp_last = 1'b0;
    key_idx = '0;
    case (state_q)
      IDLE:  ready = 1'b1;
      INIT:  key_idx = en_q ? KIDX_W'(0) : nr_q;
      ROUND: key_idx = en_q ? rnd_q : (nr_q - rnd_q);
      FINAL: begin
        dp_last = 1'b1;
        key_idx = en_q ? nr_q : KIDX_W'(0);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Block, round counter, mode and result next-state; flush freezes the result
  always_comb begin
    blk_d  = blk_q;
    dout_d = dout_q;
    rnd_d  = rnd_q;
    nr_d   = nr_q;
    en_d   = en_q;
    if (flush) begin
      rnd_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            blk_d = din;
            en_d  = en_de;
            nr_d  = sel_nr(AES256_EN, key_len);
          end
        end
        INIT: begin
          blk_d = blk_q ^ key_data;
          rnd_d = KIDX_W'(1);
        end
        ROUND: begin
          blk_d = dp_new_block;
          // Hold on the last round so the counter tops out at Nr-1 (max 13)
          if (!last_rnd) rnd_d = rnd_q + KIDX_W'(1);
        end
        FINAL:   dout_d = dp_new_block;
        DONE:    rnd_d  = '0;
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blk_q  <= '0;
      dout_q <= '0;
      rnd_q  <= '0;
      nr_q   <= KIDX_W'(NR_128);
      en_q   <= 1'b0;
    end else begin
      blk_q  <= blk_d;
      dout_q <= dout_d;
      rnd_q  <= rnd_d;
      nr_q   <= nr_d;
      en_q   <= en_d;
    end
  end

  assign dout         = dout_q;
  assign dp_block     = blk_q;
  assign dp_round_key = key_data;
  assign dp_en_de     = en_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Self-checking bench: behavioural AES round datapath and key
//                store around the controller, FIPS-197 vectors, flush/reset
//                scenarios and randomized blocks against an AES model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

  logic         clock = 1'b0;
  logic         reset_n, start, start2, en_de, key_len, flush;
  logic [127:0] din;

  logic         ready, done, dp_en_de, dp_last;
  logic [127:0] dout, key_data, dp_block, dp_round_key, dp_new_block;
  logic [3:0]   key_idx;

  logic         ready2, done2, dp_en_de2, dp_last2;
  logic [127:0] dout2, key_data2, dp_block2, dp_round_key2, dp_new_block2;
  logic [3:0]   key_idx2;

  logic [127:0] rk [16];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // ---------------- AES behavioural model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, base;
    int e;
    p = 8'h01; base = a; e = 254;
    while (e > 0) begin
      if (e % 2 == 1) p = gmul(p, base);
      base = gmul(base, base);
      e = e / 2;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // One AES round (FIPS-197 cipher / inverse cipher), MixColumns skipped when last
  function automatic logic [127:0] aes_round(input logic [127:0] b, input logic [127:0] k,
                                             input logic en, input logic last);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = b[127-8*i -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = en ? sbox(s[r+4*((c+r)%4)]) : inv_sbox(s[r+4*((c+4-r)%4)]);
    if (!en) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (en) begin
          t[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          t[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end else begin
          t[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
          t[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
          t[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
          t[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
      end
    end
    if (en) for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  // Full AES cipher / inverse cipher over the loaded key schedule
  function automatic logic [127:0] ref_cipher(input logic [127:0] b, input logic en, input int nr);
    logic [127:0] s;
    s = b ^ rk[en ? 0 : nr];
    for (int r = 1; r < nr; r++) s = aes_round(s, rk[en ? r : nr - r], en, 1'b0);
    return aes_round(s, rk[en ? nr : 0], en, 1'b1);
  endfunction

  // FIPS-197 key expansion; key is left-aligned, nk = 4 or 8 words
  task automatic load_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr = nk + 6; rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = 128'h0;
    end
  endtask

  // External key store and round datapath for both controllers
  assign key_data      = rk[key_idx];
  assign dp_new_block  = aes_round(dp_block, dp_round_key, dp_en_de, dp_last);
  assign key_data2     = rk[key_idx2];
  assign dp_new_block2 = aes_round(dp_block2, dp_round_key2, dp_en_de2, dp_last2);

  aes_round_ctrl #(.AES256_EN(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ready(ready),
    .en_de(en_de), .key_len(key_len), .din(din), .flush(flush),
    .dout(dout), .done(done), .key_idx(key_idx), .key_data(key_data),
    .dp_en_de(dp_en_de), .dp_last(dp_last), .dp_block(dp_block),
    .dp_round_key(dp_round_key), .dp_new_block(dp_new_block)
  );

  aes_round_ctrl #(.AES256_EN(1'b0)) dut128 (
    .clock(clock), .reset_n(reset_n), .start(start2), .ready(ready2),
    .en_de(en_de), .key_len(key_len), .din(din), .flush(flush),
    .dout(dout2), .done(done2), .key_idx(key_idx2), .key_data(key_data2),
    .dp_en_de(dp_en_de2), .dp_last(dp_last2), .dp_block(dp_block2),
    .dp_round_key(dp_round_key2), .dp_new_block(dp_new_block2)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int           lat, klen;
  logic [127:0] res;
  logic [63:0]  kpk;
  logic         seen, done_kidx_nz, done_last, post_done, post_ready;

  // Launch one block; if rel, reset is released on the same edge start is set
  task automatic run_op(input bit en, input bit kl, input logic [127:0] blk, input bit rel);
    @(negedge clock);
    if (rel) reset_n = 1'b1;
    start = 1'b1; en_de = en; key_len = kl; din = blk;
    @(posedge clock); #1;
    start = 1'b0; en_de = 1'($urandom); key_len = 1'($urandom);
    din = {$urandom, $urandom, $urandom, $urandom};
    lat = 0; klen = 0; kpk = 64'h0; seen = 1'b0; res = 128'hx;
    done_kidx_nz = 1'b1; done_last = 1'b1; post_done = 1'b1; post_ready = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (done) begin
        seen = 1'b1; res = dout;
        done_kidx_nz = (key_idx != 4'd0); done_last = dp_last;
      end else begin
        kpk = {kpk[59:0], key_idx}; klen++;
      end
    end
    if (seen) begin
      @(negedge clock);
      post_done = done; post_ready = ready;
    end
  endtask

  function automatic logic [63:0] exp_kseq(input bit en, input int nr);
    logic [63:0] pk;
    pk = 64'h0;
    for (int i = 0; i <= nr; i++) pk = {pk[59:0], 4'(en ? i : nr - i)};
    return pk;
  endfunction

  task automatic check_op(input string tag, input bit en, input int nr, input logic [127:0] exp);
    chk({tag, ".latency"}, 128'(lat), 128'(nr + 2));
    chk({tag, ".dout"}, res, exp);
    chk({tag, ".kidx_count"}, 128'(klen), 128'(nr + 1));
    chk({tag, ".kidx_seq"}, kpk, exp_kseq(en, nr));
    chk({tag, ".done_kidx_last"}, {done_kidx_nz, done_last}, 2'b00);
    chk({tag, ".done_one_cycle"}, {post_done, post_ready}, 2'b01);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] saved, pt_r, exp_r, mid;
    logic [255:0] key_r;
    bit           en_r, kl_r;
    int           ndone, n;
    int           dc [$];

    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; en_de = 1'b0; key_len = 1'b0;
    flush = 1'b0; din = 128'h0;
    load_key(K128, 4);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset.ready", ready, 1'b1);
    chk("reset.done", done, 1'b0);
    chk("reset.dout", dout, 128'h0);
    chk("reset.blk", dp_block, 128'h0);
    chk("reset.kidx_last_ende", {key_idx, dp_last, dp_en_de}, 6'h0);
    chk("reset.ready2", ready2, 1'b1);
    reset_n = 1'b1;

    // FIPS-197 vectors
    run_op(1'b1, 1'b0, PT, 1'b0);
    check_op("aes128_enc", 1'b1, 10, CT128);
    run_op(1'b0, 1'b0, CT128, 1'b0);
    check_op("aes128_dec", 1'b0, 10, PT);
    load_key(K256, 8);
    run_op(1'b1, 1'b1, PT, 1'b0);
    check_op("aes256_enc", 1'b1, 14, CT256);
    run_op(1'b0, 1'b1, CT256, 1'b0);
    check_op("aes256_dec", 1'b0, 14, PT);

    // Build without AES-256: key_len ignored, ten rounds
    @(negedge clock);
    start2 = 1'b1; en_de = 1'b1; key_len = 1'b1; din = PT;
    @(posedge clock); #1 start2 = 1'b0; key_len = 1'b0;
    n = 0;
    while (!done2 && n < 40) begin @(negedge clock); n++; end
    chk("no256.latency", 128'(n), 128'd12);
    chk("no256.dout", dout2, ref_cipher(PT, 1'b1, 10));

    // Flush in ROUND with rnd=5
    load_key(K128, 4);
    @(negedge clock);
    start = 1'b1; en_de = 1'b1; key_len = 1'b0; din = PT;
    @(posedge clock); #1 start = 1'b0;
    repeat (6) @(negedge clock);
    chk("flush.kidx_rnd5", key_idx, 4'd5);
    saved = dout;
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk("flush.ready", ready, 1'b1);
    ndone = 0;
    repeat (20) begin @(negedge clock); if (done) ndone++; end
    chk("flush.no_done", 128'(ndone), 128'd0);
    chk("flush.dout_hold", dout, saved);
    run_op(1'b1, 1'b0, PT, 1'b0);
    check_op("flush.after", 1'b1, 10, CT128);

    // Flush wins over start in the same cycle
    @(negedge clock);
    start = 1'b1; flush = 1'b1; din = CT128;
    @(posedge clock); #1 start = 1'b0; flush = 1'b0;
    @(negedge clock);
    chk("flush_vs_start.ready", ready, 1'b1);

    // Start held high: accepts every Nr+3 cycles
    @(negedge clock);
    start = 1'b1; en_de = 1'b1; key_len = 1'b0; din = PT;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) begin dc.push_back(c); saved = dout; end
    end
    start = 1'b0;
    chk("held.done_count", 128'(dc.size()), 128'd3);
    if (dc.size() >= 3) begin
      chk("held.first_done", 128'(dc[0]), 128'd11);
      chk("held.spacing1", 128'(dc[1] - dc[0]), 128'd13);
      chk("held.spacing2", 128'(dc[2] - dc[1]), 128'd13);
    end
    chk("held.dout", saved, CT128);
    n = 0;
    while (!ready && n < 30) begin @(negedge clock); n++; end
    chk("held.return_idle", ready, 1'b1);

    // Reset pulsed mid-ROUND
    run_op(1'b1, 1'b0, PT, 1'b0);
    @(negedge clock);
    start = 1'b1; en_de = 1'b1; din = CT128;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midreset.ready_done", {ready, done}, 2'b10);
    chk("midreset.dout", dout, 128'h0);
    chk("midreset.blk", dp_block, 128'h0);
    chk("midreset.kidx_last_ende", {key_idx, dp_last, dp_en_de}, 6'h0);
    ndone = 0;
    repeat (3) begin @(negedge clock); if (done) ndone++; end
    chk("midreset.no_done", 128'(ndone), 128'd0);
    run_op(1'b1, 1'b0, PT, 1'b1);
    check_op("midreset.after", 1'b1, 10, CT128);

    // Randomized blocks, keys and modes; each result is run back the other way
    for (int k = 0; k < 10; k++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl_r  = 1'($urandom);
      en_r  = 1'($urandom);
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key_r, kl_r ? 8 : 4);
      exp_r = ref_cipher(pt_r, en_r, kl_r ? 14 : 10);
      run_op(en_r, kl_r, pt_r, 1'b0);
      check_op($sformatf("rand%0d.fwd", k), en_r, kl_r ? 14 : 10, exp_r);
      mid = res;
      run_op(!en_r, kl_r, mid, 1'b0);
      check_op($sformatf("rand%0d.back", k), !en_r, kl_r ? 14 : 10, pt_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter AES256_EN, default 1; 1 = key_len honoured, 0 = key_len ignored and Nr fixed at 10.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to process din.
REQ-005 SHALL have port ready, output, 1, high when the controller can accept start.
REQ-006 SHALL have port en_de, input, 1, 1 = encrypt, 0 = decrypt; sampled at accept.
REQ-007 SHALL have port key_len, input, 1, 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled at accept.
REQ-008 SHALL have port din, input, 128, input block.
REQ-009 SHALL have port flush, input, 1, synchronous abort.
REQ-010 SHALL have port dout, output, 128, result block.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking dout valid.
REQ-012 SHALL have port key_idx, output, 4, round-key index into the external expanded-key store.
REQ-013 SHALL have port key_data, input, 128, round key for key_idx, returned combinationally in the same cycle.
REQ-014 SHALL have ports dp_en_de (output, 1), dp_last (output, 1), dp_block (output, 128) and dp_round_key (output, 128), which drive the combinational round datapath.
REQ-015 SHALL have port dp_new_block, input, 128, the round datapath result.

Function
REQ-016 SHALL implement states IDLE, INIT, ROUND, FINAL, DONE; ready = (state==IDLE).
REQ-017 Accept: on start&&ready, SHALL latch din into blk, latch mode/Nr, go to INIT; start in any other state is ignored.
REQ-018 INIT: key_idx = en?0:Nr; blk <= blk ^ key_data; rnd <= 1; go to ROUND.
REQ-019 ROUND: dp_last=0; key_idx = en?rnd:Nr-rnd; blk <= dp_new_block; rnd++; after the round with rnd==Nr-1, go to FINAL.
REQ-020 FINAL: dp_last=1; key_idx = en?Nr:0; dout <= dp_new_block; go to DONE.
REQ-021 DONE: done=1 for exactly one cycle; go to IDLE.
REQ-022 Outputs: dp_block=blk, dp_round_key=key_data, dp_en_de=latched mode.
REQ-023 Latency: done SHALL rise Nr+2 cycles after the accept cycle (12 for AES-128, 16 for AES-256); throughput is one block per Nr+3 cycles.
REQ-024 dout SHALL hold its value from FINAL until the next FINAL; it is unaffected by flush or new accepts.
REQ-025 flush SHALL force IDLE on the next edge from any state, suppress done, and take priority over start in the same cycle.
REQ-026 In IDLE and DONE, key_idx=0 and dp_last=0.
REQ-027 Changes on en_de or key_len mid-operation SHALL have no effect.
REQ-028 rnd SHALL be 4 bits and SHALL never exceed 13.

Reset
REQ-029 While reset_n=0: state=IDLE, ready=1, done=0, dout=0, blk=0, rnd=0, key_idx=0, dp_last=0, dp_en_de=0.
REQ-030 Reset asserted mid-operation SHALL abort immediately, with no done pulse; the first start is accepted on the first edge after release.

Structure
REQ-031 Package aes_ctrl_pkg SHALL hold the state enum and the constants NR_128=10, NR_256=14, BLK_W=128, KIDX_W=4.
REQ-032 No sub-module; the round datapath, S-boxes and key store SHALL remain outside and connect at wrapper level.

Verification
REQ-033 FIPS-197 AES-128 encrypt: key 000102..0f, pt 00112233445566778899aabbccddeeff -> dout 69c4e0d86a7b0430d8cdb78070b4c55a, done 12 cycles after accept, key_idx sequence 0,1..10.
REQ-034 AES-128 decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff, key_idx sequence 10,9..0.
REQ-035 AES-256 encrypt: key 000102..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089, done 16 cycles after accept; with AES256_EN=0, the same stimulus yields the AES-128 timing.
REQ-036 flush asserted in ROUND at rnd=5 -> IDLE next cycle, no done, dout unchanged; a following start completes correctly.
REQ-037 start held high continuously -> accepts spaced exactly Nr+3 cycles apart; start asserted while busy is ignored.
REQ-038 reset_n pulsed low mid-ROUND -> all outputs at reset values within the same cycle, no done pulse.
